// File: rtl/ras_pkg.sv
// Shared defaults, FSM state encoding and checkpoint entry layout for the RAS checkpoint controller.
package ras_pkg;
    localparam int RAS_ADDRESS_DEF = 3;
    localparam int XLEN_DEF        = 32;
    localparam int CKPT_DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        SETTLE  = 2'd2
    } ras_state_e;

    typedef struct packed {
        logic [RAS_ADDRESS_DEF-1:0] sp;
        logic [2*XLEN_DEF-1:0]      ras;
    } ras_ckpt_entry_t;
endpackage

// File: rtl/ras_ckpt_ctrl_if.sv
// Dispatch/commit/resolve handshake and RAS restore command bundle for ras_ckpt_ctrl.
interface ras_ckpt_ctrl_if import ras_pkg::*; #(
    parameter int RAS_ADDRESS = RAS_ADDRESS_DEF,
    parameter int XLEN        = XLEN_DEF,
    parameter int CKPT_DEPTH  = CKPT_DEPTH_DEF
);
    localparam int CKPT_IDX = $clog2(CKPT_DEPTH);

    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [CKPT_IDX-1:0]    alloc_tag;
    logic [RAS_ADDRESS-1:0] sp_snap;
    logic [2*XLEN-1:0]      ras_snap;
    logic                   commit_valid;
    logic                   resolve_valid;
    logic [CKPT_IDX-1:0]    resolve_tag;
    logic                   resolve_mispredict;
    logic                   restore_ras;
    logic [RAS_ADDRESS-1:0] rb_sp_snap;
    logic [2*XLEN-1:0]      rb_ras_snap;
    logic                   busy;

    modport slave (
        input  alloc_valid, sp_snap, ras_snap, commit_valid,
               resolve_valid, resolve_tag, resolve_mispredict,
        output alloc_ready, alloc_tag, restore_ras, rb_sp_snap, rb_ras_snap, busy
    );

    modport master (
        output alloc_valid, sp_snap, ras_snap, commit_valid,
               resolve_valid, resolve_tag, resolve_mispredict,
        input  alloc_ready, alloc_tag, restore_ras, rb_sp_snap, rb_ras_snap, busy
    );
endinterface

// File: rtl/ras_ckpt_mem.sv
// Checkpoint storage: one synchronous write port, one asynchronous read port, no reset.
module ras_ckpt_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 67
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ras_ckpt_ctrl.sv
// RAS checkpoint controller: circular checkpoint buffer with squash-and-restore on mispredict.
// Optional restore_count statistics output enabled by defining RAS_CKPT_STATS_EN.
module ras_ckpt_ctrl import ras_pkg::*; #(
    parameter int RAS_ADDRESS = RAS_ADDRESS_DEF,
    parameter int XLEN        = XLEN_DEF,
    parameter int CKPT_DEPTH  = CKPT_DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    ras_ckpt_ctrl_if.slave    bus
`ifdef RAS_CKPT_STATS_EN
    ,
    output logic [15:0]       restore_count
`endif
);
    localparam int CKPT_IDX = $clog2(CKPT_DEPTH);
    localparam int PW       = CKPT_IDX + 1;
    localparam int EW       = RAS_ADDRESS + 2*XLEN;

    ras_state_e             r_state, w_state_nxt;
    logic [PW-1:0]          r_head, r_tail;
    logic [PW-1:0]          w_occ, w_tag_ptr;
    logic [CKPT_IDX-1:0]    w_tag_off;
    logic                   w_full, w_empty, w_mispred, w_live_mispred;
    logic                   w_alloc_fire, w_commit_fire, w_restore;
    logic [EW-1:0]          w_rd_data;
    logic [RAS_ADDRESS-1:0] r_rb_sp;
    logic [2*XLEN-1:0]      r_rb_ras;

    assign w_occ     = r_tail - r_head;
    assign w_full    = (w_occ == PW'(CKPT_DEPTH));
    assign w_empty   = (w_occ == '0);
    assign w_mispred = bus.resolve_valid && bus.resolve_mispredict;

    // Distance of the tag from head decides liveness; rebuilding the full pointer
    // from head keeps the wrap bit correct when the buffer straddles the wrap.
    assign w_tag_off      = bus.resolve_tag - r_head[CKPT_IDX-1:0];
    assign w_tag_ptr      = r_head + {1'b0, w_tag_off};
    assign w_live_mispred = w_mispred && (r_state == IDLE) && ({1'b0, w_tag_off} < w_occ);

    assign w_alloc_fire  = bus.alloc_valid && bus.alloc_ready;
    assign w_commit_fire = bus.commit_valid && !w_empty;
    assign w_restore     = (r_state == RESTORE) && !reset;

    assign bus.alloc_ready = !reset && !w_full && (r_state == IDLE) && !w_mispred;
    assign bus.alloc_tag   = reset ? '0 : r_tail[CKPT_IDX-1:0];
    assign bus.restore_ras = w_restore;
    assign bus.busy        = !reset && (r_state != IDLE);
    assign bus.rb_sp_snap  = r_rb_sp;
    assign bus.rb_ras_snap = r_rb_ras;

    ras_ckpt_mem #(
        .DEPTH (CKPT_DEPTH),
        .AW    (CKPT_IDX),
        .DW    (EW)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_alloc_fire),
        .i_waddr (r_tail[CKPT_IDX-1:0]),
        .i_wdata ({bus.sp_snap, bus.ras_snap}),
        .i_raddr (bus.resolve_tag),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_live_mispred) w_state_nxt = RESTORE;
            RESTORE: w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_rb_sp  <= '0;
            r_rb_ras <= '0;
        end else begin
            if (w_commit_fire) r_head <= r_head + PW'(1);
            // Alloc is never accepted alongside a mispredict, so the two tail updates are exclusive.
            if (w_live_mispred) begin
                r_tail   <= w_tag_ptr + PW'(1);
                r_rb_sp  <= w_rd_data[EW-1 -: RAS_ADDRESS];
                r_rb_ras <= w_rd_data[2*XLEN-1:0];
            end else if (w_alloc_fire) begin
                r_tail <= r_tail + PW'(1);
            end
        end
    end

`ifdef RAS_CKPT_STATS_EN
    logic [15:0] r_restore_count;

    always_ff @(posedge CLK) begin
        if (reset)
            r_restore_count <= '0;
        else if (w_restore && (r_restore_count != 16'hFFFF))
            r_restore_count <= r_restore_count + 16'd1;
    end

    assign restore_count = r_restore_count;
`endif
endmodule

// File: tb/tb_ras_ckpt_ctrl.sv
// Self-checking bench for ras_ckpt_ctrl: directed scenarios plus random traffic against a queue model.
module tb_ras_ckpt_ctrl;
    import ras_pkg::*;

    logic        CLK;
    logic        reset;
    logic        av, cv, rv, rmis;
    logic [2:0]  sp, rtag;
    logic [63:0] ras;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] ras_saved [8];

    ras_ckpt_ctrl_if #(.RAS_ADDRESS(3), .XLEN(32), .CKPT_DEPTH(8)) bus ();

    assign bus.alloc_valid        = av;
    assign bus.sp_snap            = sp;
    assign bus.ras_snap           = ras;
    assign bus.commit_valid       = cv;
    assign bus.resolve_valid      = rv;
    assign bus.resolve_tag        = rtag;
    assign bus.resolve_mispredict = rmis;

`ifdef RAS_CKPT_STATS_EN
    logic [15:0] restore_count;
    ras_ckpt_ctrl #(.RAS_ADDRESS(3), .XLEN(32), .CKPT_DEPTH(8)) dut (
        .CLK(CLK), .reset(reset), .bus(bus), .restore_count(restore_count));
`else
    ras_ckpt_ctrl #(.RAS_ADDRESS(3), .XLEN(32), .CKPT_DEPTH(8)) dut (
        .CLK(CLK), .reset(reset), .bus(bus));
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: ordered list of live checkpoints, next tag to hand out,
    // and a restore countdown (2 = restore pulse cycle, 1 = settle cycle).
    typedef struct { int tag; ras_ckpt_entry_t e; } m_ent_t;
    m_ent_t      q[$];
    int          m_next = 0;
    int          m_busy = 0;
    logic [2:0]  m_rb_sp = '0;
    logic [63:0] m_rb_ras = '0;
    int          m_cnt = 0;

    function automatic bit m_ready();
        return (q.size() < 8) && (m_busy == 0) && !(rv && rmis);
    endfunction

    function automatic bit m_live(input int tag);
        foreach (q[i]) if (q[i].tag == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_update();
        bit     fire_alloc, live;
        m_ent_t n;
        if (reset) begin
            q.delete(); m_next = 0; m_busy = 0; m_rb_sp = '0; m_rb_ras = '0; m_cnt = 0;
            return;
        end
        if (m_busy == 2 && m_cnt < 16'hFFFF) m_cnt++;
        fire_alloc = av && m_ready();
        live       = rv && rmis && (m_busy == 0) && m_live(int'(rtag));
        if (m_busy != 0) m_busy--;
        if (live) begin
            while (q[$].tag != int'(rtag)) void'(q.pop_back());
            m_rb_sp  = q[$].e.sp;
            m_rb_ras = q[$].e.ras;
            m_next   = (int'(rtag) + 1) % 8;
            m_busy   = 2;
        end
        if (cv && q.size() > 0) void'(q.pop_front());
        if (fire_alloc) begin
            n.tag = m_next; n.e.sp = sp; n.e.ras = ras;
            q.push_back(n);
            m_next = (m_next + 1) % 8;
        end
    endtask

    task automatic tick();
        m_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        av = 0; cv = 0; rv = 0; rmis = 0; rtag = '0; sp = '0; ras = '0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1; tick(); tick();
        reset = 0;
    endtask

    task automatic alloc_one(input logic [2:0] s);
        av = 1; sp = s; ras = {$urandom, $urandom};
        ras_saved[m_next] = ras;
        tick();
        av = 0;
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1; av = 1;
        tick();
        #2;
        checks++;
        if (bus.restore_ras !== 1'b0 || bus.busy !== 1'b0 || bus.alloc_tag !== 3'd0 ||
            bus.rb_sp_snap !== 3'd0 || bus.rb_ras_snap !== 64'd0 || bus.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: restore=%b busy=%b tag=%0d rb_sp=%0d rb_ras=%h ready=%b, want all zero",
                     bus.restore_ras, bus.busy, bus.alloc_tag, bus.rb_sp_snap, bus.rb_ras_snap, bus.alloc_ready);
        end
        av = 0;
        tick();
        reset = 0;
        #2;
        checks++;
        if (bus.alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.alloc_ready);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            av = 1; sp = 3'(i); ras = {$urandom, $urandom};
            #2;
            checks++;
            if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 3'(i)) begin
                errors++;
                $display("FAIL fill_tag%0d: ready=%b tag=%0d want ready=1 tag=%0d", i, bus.alloc_ready, bus.alloc_tag, i);
            end
            tick();
        end
        av = 1;
        #2;
        checks++;
        if (bus.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: ready=%b want 0", bus.alloc_ready);
        end
        tick();
        av = 0; cv = 1;
        tick();
        cv = 0; av = 1;
        #2;
        checks++;
        if (bus.alloc_ready !== 1'b1 || bus.alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL fill_after_commit: ready=%b tag=%0d want ready=1 tag=0", bus.alloc_ready, bus.alloc_tag);
        end
        tick();
        av = 0;
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 5; i++) alloc_one(3'(i + 1));
        rv = 1; rmis = 1; rtag = 3'd2; av = 1;
        #2;
        checks++;
        if (bus.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL misp_alloc_block: ready=%b want 0", bus.alloc_ready);
        end
        tick();
        // A live resolve arriving during the restore must be ignored.
        rv = 1; rmis = 1; rtag = 3'd0; av = 1;
        #2;
        checks++;
        if (bus.restore_ras !== 1'b1 || bus.rb_sp_snap !== 3'd3 || bus.rb_ras_snap !== ras_saved[2] ||
            bus.busy !== 1'b1 || bus.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL misp_restore: restore=%b rb_sp=%0d rb_ras=%h busy=%b ready=%b want 1 3 %h 1 0",
                     bus.restore_ras, bus.rb_sp_snap, bus.rb_ras_snap, bus.busy, bus.alloc_ready, ras_saved[2]);
        end
        tick();
        idle_in();
        #2;
        checks++;
        if (bus.restore_ras !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL misp_settle: restore=%b busy=%b want 0 1", bus.restore_ras, bus.busy);
        end
        tick();
        #2;
        checks++;
        if (bus.busy !== 1'b0 || bus.alloc_tag !== 3'd3 || bus.alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL misp_next_tag: busy=%b tag=%0d ready=%b want 0 3 1", bus.busy, bus.alloc_tag, bus.alloc_ready);
        end
        alloc_one(3'd7);
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) alloc_one(3'(i));
        cv = 1;
        for (int i = 0; i < 6; i++) tick();
        cv = 0;
        alloc_one(3'd0);
        alloc_one(3'd1);
        #2;
        checks++;
        if (bus.alloc_tag !== 3'd2) begin
            errors++;
            $display("FAIL wrap_setup: tag=%0d want 2", bus.alloc_tag);
        end
        rv = 1; rmis = 1; rtag = 3'd7;
        tick();
        idle_in();
        #2;
        checks++;
        if (bus.restore_ras !== 1'b1 || bus.rb_sp_snap !== 3'd7 || bus.rb_ras_snap !== ras_saved[7]) begin
            errors++;
            $display("FAIL wrap_restore: restore=%b rb_sp=%0d rb_ras=%h want 1 7 %h",
                     bus.restore_ras, bus.rb_sp_snap, bus.rb_ras_snap, ras_saved[7]);
        end
        tick(); tick();
        #2;
        checks++;
        if (bus.alloc_tag !== 3'd0) begin
            errors++;
            $display("FAIL wrap_tail: tag=%0d want 0", bus.alloc_tag);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            av = 1; sp = 3'(i);
            #2;
            if (bus.alloc_ready === 1'b1) n++;
            tick();
        end
        av = 0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL wrap_free_slots: accepted=%0d want 6", n);
        end
    endtask

    task automatic test_collision();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(3'(i + 1));
        rv = 1; rmis = 1; rtag = 3'd1; cv = 1; av = 1;
        #2;
        checks++;
        if (bus.alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_alloc_reject: ready=%b want 0", bus.alloc_ready);
        end
        tick();
        idle_in();
        #2;
        checks++;
        if (bus.restore_ras !== 1'b1 || bus.rb_sp_snap !== 3'd2) begin
            errors++;
            $display("FAIL coll_restore: restore=%b rb_sp=%0d want 1 2", bus.restore_ras, bus.rb_sp_snap);
        end
        tick(); tick();
        #2;
        checks++;
        if (bus.alloc_tag !== 3'd2) begin
            errors++;
            $display("FAIL coll_tail: tag=%0d want 2", bus.alloc_tag);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            av = 1;
            #2;
            if (bus.alloc_ready === 1'b1) n++;
            tick();
        end
        av = 0;
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL coll_head: accepted=%0d want 7", n);
        end
    endtask

    task automatic test_robust();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(3'(i));
        rv = 1; rmis = 1; rtag = 3'd5;
        tick();
        idle_in();
        #2;
        checks++;
        if (bus.restore_ras !== 1'b0 || bus.busy !== 1'b0 || bus.alloc_tag !== 3'd3) begin
            errors++;
            $display("FAIL dead_tag: restore=%b busy=%b tag=%0d want 0 0 3", bus.restore_ras, bus.busy, bus.alloc_tag);
        end
        rv = 1; rmis = 1; rtag = 3'd1;
        tick();
        idle_in();
        reset = 1;
        #2;
        checks++;
        if (bus.restore_ras !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_restore: restore=%b want 0", bus.restore_ras);
        end
        tick();
        reset = 0;
        #2;
        checks++;
        if (bus.alloc_tag !== 3'd0 || bus.busy !== 1'b0 || bus.alloc_ready !== 1'b1 || bus.restore_ras !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears: tag=%0d busy=%b ready=%b restore=%b want 0 0 1 0",
                     bus.alloc_tag, bus.busy, bus.alloc_ready, bus.restore_ras);
        end
        cv = 1;
        tick();
        cv = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            av = 1;
            #2;
            if (bus.alloc_ready === 1'b1) n++;
            tick();
        end
        av = 0;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL empty_commit: accepted=%0d want 8", n);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            av   = ($urandom_range(0, 1) == 1);
            cv   = ($urandom_range(0, 4) < 2);
            rv   = ($urandom_range(0, 3) == 0);
            rmis = ($urandom_range(0, 1) == 1);
            rtag = 3'($urandom);
            sp   = 3'($urandom);
            ras  = {$urandom, $urandom};
            #2;
            checks++;
            if (bus.alloc_ready !== m_ready() || bus.alloc_tag !== 3'(m_next)) begin
                errors++;
                $display("FAIL rand_alloc c=%0d: ready=%b tag=%0d want ready=%b tag=%0d",
                         c, bus.alloc_ready, bus.alloc_tag, m_ready(), m_next);
            end
            checks++;
            if (bus.restore_ras !== (m_busy == 2) || bus.busy !== (m_busy != 0) ||
                bus.rb_sp_snap !== m_rb_sp || bus.rb_ras_snap !== m_rb_ras) begin
                errors++;
                $display("FAIL rand_restore c=%0d: restore=%b busy=%b rb_sp=%0d rb_ras=%h want %b %b %0d %h",
                         c, bus.restore_ras, bus.busy, bus.rb_sp_snap, bus.rb_ras_snap,
                         (m_busy == 2), (m_busy != 0), m_rb_sp, m_rb_ras);
            end
            tick();
        end
        idle_in();
`ifdef RAS_CKPT_STATS_EN
        tick(); tick();
        #2;
        checks++;
        if (restore_count !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL restore_count: got %0d want %0d", restore_count, m_cnt);
        end
`endif
    endtask

    initial begin
        idle_in();
        reset = 1;
        test_reset();
        test_fill();
        test_mispredict();
        test_wrap();
        test_collision();
        test_robust();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ras_ckpt_ctrl.md
RAS_CKPT_CTRL -- requirements
Module: ras_ckpt_ctrl

Interface
REQ-001 SHALL have parameter RAS_ADDRESS, default 3, RAS stack-pointer width.
REQ-002 SHALL have parameter XLEN, default 32, return-address width.
REQ-003 SHALL have parameter CKPT_DEPTH, default 8, checkpoint entries (power of 2); CKPT_IDX = log2(CKPT_DEPTH).
REQ-004 SHALL have port CLK  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports alloc_valid  in  1  branch/call/ret dispatched, needs checkpoint; alloc_ready  out  1  entry available; alloc_tag  out  CKPT_IDX  index granted.
REQ-007 SHALL have ports sp_snap  in  RAS_ADDRESS  and ras_snap  in  2*XLEN  RAS snapshot captured on accepted alloc.
REQ-008 SHALL have ports commit_valid  in  1  oldest checkpointed instruction retired.
REQ-009 SHALL have ports resolve_valid  in  1, resolve_tag  in  CKPT_IDX, resolve_mispredict  in  1  branch outcome.
REQ-010 SHALL have ports restore_ras  out  1, rb_sp_snap  out  RAS_ADDRESS, rb_ras_snap  out  2*XLEN  RAS restore command.
REQ-011 SHALL have port busy  out  1  restore sequence in progress.

Function
REQ-012 SHALL hold checkpoints in a circular buffer with head/tail pointers of CKPT_IDX+1 bits (wrap bit); occupancy = tail - head.
REQ-013 SHALL drive alloc_ready = (occupancy != CKPT_DEPTH) && state==IDLE && !(resolve_valid && resolve_mispredict), combinationally.
REQ-014 SHALL, on alloc_valid && alloc_ready, write {sp_snap, ras_snap} at tail[CKPT_IDX-1:0], present that index on alloc_tag in the same cycle, increment tail.
REQ-015 SHALL, on commit_valid with occupancy != 0, increment head; commit on empty buffer is ignored.
REQ-016 SHALL treat a tag as live iff it lies in [head, tail) modulo wrap; resolve on a non-live tag is ignored.
REQ-017 SHALL, on correct resolve (resolve_mispredict=0), change no state.
REQ-018 SHALL FSM states IDLE, RESTORE, SETTLE; IDLE->RESTORE on live mispredict; RESTORE->SETTLE unconditionally; SETTLE->IDLE unconditionally.
REQ-019 SHALL, on live mispredict in IDLE, set tail = resolve_tag+1 (squash younger entries incl. wrap bit) and register entry data into rb_sp_snap/rb_ras_snap.
REQ-020 SHALL assert restore_ras for exactly the one cycle in RESTORE; rb_* valid that cycle.
REQ-021 SHALL hold SETTLE one cycle so registered RAS outputs reflect restored sp before next alloc; busy = (state != IDLE).
REQ-022 SHALL ignore resolve_valid while busy; commit_valid remains honoured in all states.
REQ-023 SHALL, on simultaneous commit and mispredict, apply both: head+1, tail=resolve_tag+1.
REQ-024 SHALL, on simultaneous alloc_valid and mispredict, reject the alloc (alloc_ready low).

Reset
REQ-025 SHALL on reset: head=tail=0, state=IDLE, restore_ras=0, rb_sp_snap=0, rb_ras_snap=0, busy=0, alloc_tag=0; alloc_ready=1 the cycle after reset deasserts.
REQ-026 SHALL let reset override any in-flight restore; restore_ras never asserts in a cycle where reset is high.
REQ-027 SHALL not reset checkpoint storage contents.

Configuration
REQ-028 SHALL with RAS_CKPT_STATS_EN defined add output restore_count (16 bits): counts restore_ras pulses, saturates at 16'hFFFF, clears on reset.
REQ-029 SHALL without RAS_CKPT_STATS_EN omit the port and counter entirely; all other behaviour identical.

Structure
REQ-030 SHALL place RAS_ADDRESS, XLEN, CKPT_DEPTH defaults, the FSM state enum and the checkpoint entry struct {sp, ras} in package ras_pkg.
REQ-031 SHALL implement storage as sub-module ras_ckpt_mem (1 write, 1 async read port, distributed RAM); pointers, FSM and squash logic in ras_ckpt_ctrl.

Verification
REQ-032 SHALL cover fill: 8 allocs, no commit -> tags 0..7, alloc_ready=0 after 8th; one commit -> alloc_ready=1, next tag 0.
REQ-033 SHALL cover mispredict: allocs tags 0..4 (sp 1..5), mispredict tag 2 -> next cycle restore_ras=1, rb_sp_snap=3, next 2 cycles busy=1, next alloc tag=3.
REQ-034 SHALL cover wrap: head=6, tail=10 (entries 6,7,0,1), mispredict tag 7 -> tail=8, occupancy=2.
REQ-035 SHALL cover collisions: mispredict tag 1 + commit same cycle with head=0 -> head=1, tail=2; alloc in same cycle rejected.
REQ-036 SHALL cover robustness: resolve on dead tag 5 with head=0, tail=3 -> no restore; reset asserted in RESTORE -> restore_ras=0, occupancy=0 next cycle.
